// File: rtl/audio_sample_feeder.sv
// Paces buffered 16-bit audio samples out at one write strobe every DIV clocks.
// A FIFO is pre-filled to PRIME entries first; if it runs dry, zero samples are sent.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | flushed, no output; waits for en
// ST_PRIME | accepting samples until the FIFO holds PRIME entries
// ST_RUN   | one strobe per DIV cycles; pops a sample or inserts a zero
module audio_sample_feeder #(
    parameter int DIV   = 3125,
    parameter int DEPTH = 16,
    parameter int PRIME = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [15:0]              s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [15:0]              x_i,
    output logic                     write,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              sample_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LOAD  = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   PRIME_LVL = (AW+1)'(PRIME);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [DW-1:0]   div_cnt;
    logic [15:0]     mem [DEPTH];
    logic            full;
    logic            empty;
    logic            push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign s_ready = (state != ST_IDLE) && !full;
    assign push    = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            div_cnt      <= '0;
            x_i          <= '0;
            write        <= 1'b0;
            underrun     <= 1'b0;
            sample_count <= '0;
        end else begin
            write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wr_ptr       <= '0;
                    rd_ptr       <= '0;
                    div_cnt      <= '0;
                    underrun     <= 1'b0;
                    sample_count <= '0;
                    if (en) begin
                        state <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (!en) begin
                        state        <= ST_IDLE;
                        wr_ptr       <= '0;
                        rd_ptr       <= '0;
                        div_cnt      <= '0;
                        underrun     <= 1'b0;
                        sample_count <= '0;
                    end else begin
                        if (push) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                        end
                        if (level >= PRIME_LVL) begin
                            state   <= ST_RUN;
                            div_cnt <= DIV_LOAD;
                        end
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        // Dropping en suppresses any tick due this cycle.
                        state        <= ST_IDLE;
                        wr_ptr       <= '0;
                        rd_ptr       <= '0;
                        div_cnt      <= '0;
                        underrun     <= 1'b0;
                        sample_count <= '0;
                    end else begin
                        if (push) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                        end
                        if (div_cnt == '0) begin
                            div_cnt      <= DIV_LOAD;
                            write        <= 1'b1;
                            sample_count <= sample_count + 32'd1;
                            // Empty is judged before any same-cycle push lands.
                            if (!empty) begin
                                x_i    <= mem[rd_ptr[AW-1:0]];
                                rd_ptr <= rd_ptr + PTR_ONE;
                            end else begin
                                x_i      <= '0;
                                underrun <= 1'b1;
                            end
                        end else begin
                            div_cnt <= div_cnt - DIV_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/audio_sample_feeder.md
# audio_sample_feeder

Paces a stream of 16-bit signed audio samples into the speech front end (MFCC → HMM → viterbi) as the `x_i`/`write` source.

- Accepts samples from an upstream producer (ADC capture, host DMA, or testbench file reader) over a valid/ready handshake and buffers them in a small FIFO.
- Emits exactly one `write` strobe per sampling period, derived from `clk` by a programmable divider.
- Pre-fills the FIFO before the first output sample, then keeps the output rate fixed even if the producer stalls. On a stall it inserts zero samples and flags underrun.

## Interface
Parameters:
- `DIV`, 3125, clk cycles per output sample (50 MHz / 16 kHz); ≥ 2
- `DEPTH`, 16, FIFO entries; power of two, ≥ 4
- `PRIME`, 8, FIFO level required before output starts; 1..`DEPTH`

Ports:
- `clk` in 1: single clock for the whole block
- `reset` in 1: asynchronous, active-low reset
- `en` in 1: run enable; low = idle and flush
- `s_data` in 16: signed input sample
- `s_valid` in 1: `s_data` valid
- `s_ready` out 1: FIFO can accept a sample this cycle
- `x_i` out 16: signed sample to the front end
- `write` out 1: one-cycle strobe; `x_i` is valid
- `underrun` out 1: sticky; at least one zero sample was inserted
- `level` out log2(`DEPTH`)+1: current FIFO occupancy
- `sample_count` out 32: number of `write` strobes since leaving IDLE

## Operation
- **Reset values:** `s_ready`=0, `x_i`=0, `write`=0, `underrun`=0, `level`=0, `sample_count`=0, state=IDLE, divider=0.
- **Push:** a sample is accepted when `s_valid` && `s_ready`.
  - `s_ready` = (state≠IDLE) && (`level` < `DEPTH`).
  - There is no combinational path from `s_valid` to `s_ready`.
- **FIFO:** circular buffer with read/write pointers one bit wider than the address.
  - Full: pointer MSBs differ and the address bits are equal.
  - Empty: pointers are equal.
  - Both pointers wrap modulo 2·`DEPTH`.
- **State IDLE:**
  - Pointers are cleared, so the FIFO is flushed. `sample_count` is cleared. `write`=0.
  - `en`=1 → PRIME.
- **State PRIME:**
  - Accepts pushes. No output.
  - `level` ≥ `PRIME` → RUN, with the divider loaded to `DIV`-1.
  - `en`=0 → IDLE.
- **State RUN:**
  - The divider decrements every cycle.
  - When the divider is 0 it reloads `DIV`-1 and a tick occurs.
  - On a tick with the FIFO non-empty: pop the head into `x_i` and pulse `write`=1.
  - On a tick with the FIFO empty: `x_i`=0, `write`=1, `underrun`=1.
  - Every tick increments `sample_count`, which wraps at 2^32.
  - `en`=0 → IDLE.
- **Push and tick in the same cycle:** the empty test uses the level before the push, so an empty FIFO still underruns. If the FIFO is not empty, `level` is unchanged.
- **`underrun`:** cleared only by reset or on entry to IDLE. It is never cleared in RUN.
- **`x_i` between strobes:** holds its last value.
- **`en` dropped mid-RUN:** the next cycle is IDLE with `write`=0, and no partial strobe is issued. A tick coinciding with `en`=0 is suppressed.

## Timing
- All outputs are registered. `x_i` and `write` update on the same edge.
- `write` is high for exactly 1 cycle per `DIV` cycles in RUN.
- The first strobe occurs `DIV` cycles after the PRIME→RUN edge.
- `level` reflects pushes and pops on the cycle after the edge that caused them.
- `s_ready` deasserts in the cycle after the FIFO reaches `DEPTH`.
- PRIME→RUN occurs on the edge after `level` reaches `PRIME`.
- Maximum push throughput is one sample per cycle.
- An asynchronous reset mid-operation forces the reset values immediately. Operation resumes from IDLE after reset deasserts, with no strobe in the deassert cycle.

## Test plan
- **Reset/idle:** hold `reset`=0, then release with `en`=0 → all outputs 0; `s_ready`=0; no `write` over 10000 cycles.
- **Prime and pace:** `DIV`=10, `PRIME`=4; push 1,2,3,4 back-to-back after `en`=1 → RUN one cycle after `level`=4; `write` at +10, +20, +30, +40 cycles with `x_i`=1,2,3,4; `sample_count`=4.
- **Underrun:** continue the prior case with no pushes → 5th strobe has `x_i`=0 and `underrun`=1 the same cycle; `write` period stays 10.
- **Full:** `DEPTH`=16, `PRIME`=16, `s_valid` held high with values 0..20 → `s_ready` drops after 16 accepts; the first 16 outputs are 0..15; sample 16 is accepted only after the first pop.
- **Simultaneous push/tick:** FIFO empty in RUN, push asserted on the tick cycle → zero strobe plus underrun; the pushed value appears on the next strobe.
- **`en` drop and reset mid-RUN:** `en`=0 with `level`=5 → `level`=0, `underrun` cleared, no further `write`. A separate async reset pulse mid-period → `write`=0 and `x_i`=0 immediately.
